// File: rtl/div_pkg.sv
// Shared state encoding and constants for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIVZERO_QUOT = '1;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational N-bit subtractor (a + ~b + 1) built on a parallel-prefix carry network.
// borrow is high when a < b (unsigned).
module div_sub_stage #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int LEVELS = $clog2(N);

    logic [N-1:0] bx;
    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] gcur;
    logic [N-1:0] pcur;
    logic [N:0]   c;

    // The constant carry-in of 1 is folded into bit 0's generate term.
    always_comb begin
        bx   = ~b;
        p    = a ^ bx;
        g    = a & bx;
        gcur = {g[N-1:1], g[0] | p[0]};
        pcur = p;
        for (int l = 0; l < LEVELS; l++) begin
            gcur = gcur | (pcur & (gcur << (1 << l)));
            pcur = pcur & ((pcur << (1 << l)) | ~({N{1'b1}} << (1 << l)));
        end
        c      = {gcur, 1'b1};
        diff   = p ^ c[N-1:0];
        borrow = ~c[N];
    end

endmodule

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: quotient feeds LO, remainder feeds HI.
// Define DIVZERO_FAST_EN to let a zero divisor skip the iterations and finish early.
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cancel,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    div_state_t       next_state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             neg_dvd;
    logic             neg_quo;
    logic             dz;
    logic             borrow;
    logic             accept;
    logic             rem_msb_unused;

    assign accept      = ((state == IDLE) || (state == DONE)) && start && !cancel;
    assign rem_shift   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign rem_next    = borrow ? rem_shift : trial;
    assign div_by_zero = dz;

    // The kept partial remainder is always below the divisor, so its top bit stays clear.
    assign rem_msb_unused = rem[WIDTH];

    div_sub_stage #(.N(WIDTH + 1)) u_sub (
        .a      (rem_shift),
        .b      ({1'b0, dvs_abs}),
        .diff   (trial),
        .borrow (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (accept) begin
`ifdef DIVZERO_FAST_EN
                    next_state = (divisor == '0) ? FIX : RUN;
`else
                    next_state = RUN;
`endif
                end
            end
            RUN: begin
                if (cancel) begin
                    next_state = IDLE;
                end else if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = cancel ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == FIX);
        done = (state == DONE);
    end

    always_comb begin
        quo_fix = neg_quo ? -quo : quo;
        rem_fix = neg_dvd ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        if (dz) begin
            quo_fix = {WIDTH{DIVZERO_QUOT[0]}};
            rem_fix = dvd_raw;
        end
    end

    // Operands are stored as magnitudes; the signs are reapplied in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs_abs <= '0;
            dvd_raw <= '0;
            neg_dvd <= 1'b0;
            neg_quo <= 1'b0;
            dz      <= 1'b0;
        end else if (accept) begin
            neg_dvd <= is_signed && dividend[WIDTH-1];
            neg_quo <= is_signed && (dividend[WIDTH-1] != divisor[WIDTH-1]);
            dvd_raw <= dividend;
            quo     <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs_abs <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            rem     <= '0;
            count   <= CNT_W'(WIDTH - 1);
            dz      <= (divisor == '0);
        end else if (state == RUN) begin
            rem   <= rem_next;
            quo   <= {quo[WIDTH-2:0], ~borrow};
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
        end else if ((state == FIX) && !cancel) begin
            quotient  <= quo_fix;
            remainder <= rem_fix;
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Randomised self-checking bench for iterative_divider against an arithmetic reference model.
// Honours DIVZERO_FAST_EN for the expected zero-divisor latency.
module tb_iterative_divider;

    localparam int WIDTH      = 32;
    localparam int LAT_FULL   = WIDTH + 1;
    localparam int EDGE_LIMIT = 200;
`ifdef DIVZERO_FAST_EN
    localparam bit FAST_DZ = 1'b1;
`else
    localparam bit FAST_DZ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             cancel;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] last_q;
    logic [31:0] last_r;

    iterative_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cancel      (cancel),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // MIPS semantics: truncating division, remainder takes the dividend's sign.
    task automatic refDivide(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa;
        longint sb;
        dz = (b == 32'd0);
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endtask

    function automatic int expLatency(input logic [31:0] b);
        return (FAST_DZ && (b == 32'd0)) ? 1 : LAT_FULL;
    endfunction

    task automatic waitDone(output int edges);
        edges = 0;
        while (!done && edges < EDGE_LIMIT) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // One full operation from IDLE; operands are scrambled after accept to prove capture.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          edges;
        refDivide(sgn, a, b, q, r, dz);
        @(negedge clk);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        checkOutput({tag, "/busy"}, 32'(busy), 32'd1);
        waitDone(edges);
        checkOutput({tag, "/latency"}, edges, expLatency(b));
        checkOutput({tag, "/quotient"}, quotient, q);
        checkOutput({tag, "/remainder"}, remainder, r);
        checkOutput({tag, "/div_by_zero"}, 32'(div_by_zero), 32'(dz));
        checkOutput({tag, "/busy_in_done"}, 32'(busy), 32'd0);
        last_q = q;
        last_r = r;
        @(negedge clk);
        checkOutput({tag, "/done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        saw_done;
        logic [31:0] qa, ra, qb, rb;
        logic        dza, dzb;
        int          edges;

        rst_n     = 1'b0;
        start     = 1'b0;
        cancel    = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset/busy", 32'(busy), 32'd0);
        checkOutput("reset/done", 32'(done), 32'd0);
        checkOutput("reset/quotient", quotient, 32'd0);
        checkOutput("reset/remainder", remainder, 32'd0);
        checkOutput("reset/div_by_zero", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 32'd100, 32'd7, "divu_100_7");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        applyStimulus(1'b0, 32'h1234_5678, 32'd0, "divu_by_zero");
        applyStimulus(1'b1, 32'hFFFF_FFF8, 32'd0, "div_by_zero_neg");

        // Cancel sampled on the 10th edge counting the accepting edge as the first.
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            saw_done |= done;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checkOutput("cancel/busy", 32'(busy), 32'd0);
        repeat (40) begin
            saw_done |= done;
            @(negedge clk);
        end
        checkOutput("cancel/no_done", 32'(saw_done), 32'd0);
        checkOutput("cancel/quotient_held", quotient, last_q);
        checkOutput("cancel/remainder_held", remainder, last_r);
        applyStimulus(1'b0, 32'd9, 32'd4, "restart_9_4");

        @(negedge clk);
        dividend = 32'd21;
        divisor  = 32'd3;
        start    = 1'b1;
        cancel   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("idle_cancel/busy", 32'(busy), 32'd0);
        checkOutput("idle_cancel/done", 32'(done), 32'd0);

        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            applyStimulus(sgn, a, b, $sformatf("rand%0d", i));
        end

        // start held high: extra requests while busy are ignored, the DONE cycle accepts the next one.
        sgn = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = $urandom | 32'd1;
        refDivide(sgn, a, b, qa, ra, dza);
        @(negedge clk);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        edges = 0;
        while (!done && edges < EDGE_LIMIT) begin
            dividend  = $urandom;
            divisor   = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            edges++;
        end
        checkOutput("b2b_first/latency", edges, LAT_FULL);
        checkOutput("b2b_first/quotient", quotient, qa);
        checkOutput("b2b_first/remainder", remainder, ra);
        sgn = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = 32'($urandom_range(1, 1000));
        refDivide(sgn, a, b, qb, rb, dzb);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        edges = 1;
        while (!done && edges < EDGE_LIMIT) begin
            dividend  = $urandom;
            divisor   = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        checkOutput("b2b_second/gap", edges, WIDTH + 2);
        checkOutput("b2b_second/quotient", quotient, qb);
        checkOutput("b2b_second/remainder", remainder, rb);
        checkOutput("b2b_second/div_by_zero", 32'(div_by_zero), 32'(dzb));
        @(negedge clk);
        checkOutput("b2b_end/done", 32'(done), 32'd0);
        checkOutput("b2b_end/busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of an operation.
        applyStimulus(1'b0, 32'd1000, 32'd3, "pre_reset");
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd77;
        divisor   = 32'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset/busy", 32'(busy), 32'd0);
        checkOutput("async_reset/done", 32'(done), 32'd0);
        checkOutput("async_reset/quotient", quotient, 32'd0);
        checkOutput("async_reset/remainder", remainder, 32'd0);
        checkOutput("async_reset/div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
